ps2_mouse_to_host: RTL and testbench

- Receive path of the PS/2 mouse interface, paired with the host-to-mouse transmitter.
- Synchronises and deglitches the device-driven ps2_clk/ps2_data lines.
- Deframes 11-bit device-to-host frames and reports each byte, so the command sequencer can see ACK 0xFA.
- Once enabled, assembles standard 3-byte movement packets into button and signed delta outputs for the cursor logic.

---
 rtl/ps2_mouse_to_host.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_mouse_to_host.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_to_host.sv
// PS/2 mouse receive path: line conditioning, 11-bit frame deframing with
// odd-parity checking, an inter-edge timeout, and 3-byte movement packet assembly.
module ps2_mouse_to_host #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       pkt_en,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic       pkt_valid,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [2:0] btn,
  output logic [1:0] ovf
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frameState_e;

  logic [1:0]    clkSync_q, dataSync_q;
  logic [FW-1:0] filtCnt_q;
  logic          filtClk_q, filtClkPrev_q;
  logic          fallEdge, dataBit;
  frameState_e   frameState_q, frameState_d;
  logic [7:0]    shift_q;
  logic [2:0]    bitCnt_q;
  logic          parity_q;
  logic          stopOk, stopBad, toAbort, toHit;
  logic [TW-1:0] toCnt_q;
  logic [7:0]    rxByte_q;
  logic          rxByteValid_q, frameErr_q;
  logic [1:0]    pktIdx_q;
  logic [6:0]    hdr_q;
  logic [7:0]    byte1_q;
  logic          pktValid_q;
  logic [8:0]    dx_q, dy_q;
  logic [2:0]    btn_q;
  logic [1:0]    ovf_q;

  assign fallEdge = filtClkPrev_q & ~filtClk_q;
  assign dataBit  = dataSync_q[1];
  assign toHit    = !fallEdge && (toCnt_q == TO_LAST);

  // Two-stage synchronisers for both asynchronous PS/2 lines, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk};
      dataSync_q <= {dataSync_q[0], ps2_data};
    end
  end

  // Deglitch filter: the clock level flips only after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      filtCnt_q     <= '0;
      filtClk_q     <= 1'b1;
      filtClkPrev_q <= 1'b1;
    end else begin
      filtClkPrev_q <= filtClk_q;
      if (clkSync_q[1] == filtClk_q) begin
        filtCnt_q <= '0;
      end else if (filtCnt_q == FILT_LAST) begin
        filtClk_q <= clkSync_q[1];
        filtCnt_q <= '0;
      end else begin
        filtCnt_q <= filtCnt_q + 1'b1;
      end
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) frameState_q <= StIdle;
    else     frameState_q <= frameState_d;
  end

  // Frame FSM next state: one step per filtered falling edge, abort to idle on timeout.
  always_comb begin
    frameState_d = frameState_q;
    if (fallEdge) begin
      case (frameState_q)
        StIdle:   if (!dataBit) frameState_d = StData;
        StData:   if (bitCnt_q == 3'd7) frameState_d = StParity;
        StParity: frameState_d = StStop;
        StStop:   frameState_d = StIdle;
        default:  frameState_d = StIdle;
      endcase
    end else if (toAbort) begin
      frameState_d = StIdle;
    end
  end

  // Frame FSM outputs: stop-bit verdict and timeout abort.
  always_comb begin
    stopOk  = 1'b0;
    stopBad = 1'b0;
    toAbort = 1'b0;
    if (fallEdge && frameState_q == StStop) begin
      if (dataBit && (^{shift_q, parity_q})) stopOk = 1'b1;
      else                                   stopBad = 1'b1;
    end
    if (toHit && frameState_q != StIdle) toAbort = 1'b1;
  end

  // Frame datapath: shift data LSB first and capture the parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      bitCnt_q <= '0;
      parity_q <= 1'b0;
    end else if (fallEdge) begin
      case (frameState_q)
        StIdle:   bitCnt_q <= '0;
        StData: begin
          shift_q  <= {dataBit, shift_q[7:1]};
          bitCnt_q <= bitCnt_q + 3'd1;
        end
        StParity: parity_q <= dataBit;
        default:  ;
      endcase
    end
  end

  // Inter-edge timeout counter: clears on each falling edge, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst)                    toCnt_q <= '0;
    else if (fallEdge)          toCnt_q <= '0;
    else if (toCnt_q != TO_MAX) toCnt_q <= toCnt_q + 1'b1;
  end

  // Byte report: load on a good frame, pulse an error on a bad frame or aborted frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxByte_q      <= '0;
      rxByteValid_q <= 1'b0;
      frameErr_q    <= 1'b0;
    end else begin
      rxByteValid_q <= stopOk;
      frameErr_q    <= stopBad | toAbort;
      if (stopOk) rxByte_q <= shift_q;
    end
  end

  // Packet assembler: resync on header bit 3, publish all fields together on the third byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      pktIdx_q   <= '0;
      hdr_q      <= '0;
      byte1_q    <= '0;
      pktValid_q <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      btn_q      <= '0;
      ovf_q      <= '0;
    end else begin
      pktValid_q <= 1'b0;
      if (!pkt_en || frameErr_q || toHit) begin
        pktIdx_q <= '0;
      end else if (rxByteValid_q) begin
        case (pktIdx_q)
          2'd0: begin
            if (rxByte_q[3]) begin
              hdr_q    <= {rxByte_q[7:4], rxByte_q[2:0]};
              pktIdx_q <= 2'd1;
            end
          end
          2'd1: begin
            byte1_q  <= rxByte_q;
            pktIdx_q <= 2'd2;
          end
          2'd2: begin
            dx_q       <= {hdr_q[3], byte1_q};
            dy_q       <= {hdr_q[4], rxByte_q};
            btn_q      <= hdr_q[2:0];
            ovf_q      <= hdr_q[6:5];
            pktValid_q <= 1'b1;
            pktIdx_q   <= 2'd0;
          end
          default: pktIdx_q <= 2'd0;
        endcase
      end
    end
  end

  assign rx_byte       = rxByte_q;
  assign rx_byte_valid = rxByteValid_q;
  assign frame_err     = frameErr_q;
  assign pkt_valid     = pktValid_q;
  assign dx            = dx_q;
  assign dy            = dy_q;
  assign btn           = btn_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_ps2_mouse_to_host.sv
// Bench for ps2_mouse_to_host: drives PS/2 frames and compares captured pulses
// against a packet-level reference model.
`timescale 1ns/1ps
module tb_ps2_mouse_to_host;

  localparam int TO   = 400;
  localparam int HALF = 30;
  localparam int GAP  = 40;

  typedef struct packed {
    logic [8:0] dx;
    logic [8:0] dy;
    logic [2:0] btn;
    logic [1:0] ovf;
  } pkt_t;

  logic       clk = 1'b0;
  logic       rst, ps2Clk, ps2Data, pktEn;
  logic [7:0] rxByte;
  logic       rxByteValid, frameErr, pktValid;
  logic [8:0] dx, dy;
  logic [2:0] btn;
  logic [1:0] ovf;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] gotBytes[$];
  pkt_t       gotPkts[$];
  int         gotErr;
  logic [7:0] expBytes[$];
  pkt_t       expPkts[$];
  int         expErr;
  int         mIdx;
  logic [7:0] m0, m1, lastGood;
  logic       prevRx, prevErr, prevPkt;

  ps2_mouse_to_host #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2Clk), .ps2_data(ps2Data), .pkt_en(pktEn),
    .rx_byte(rxByte), .rx_byte_valid(rxByteValid), .frame_err(frameErr),
    .pkt_valid(pktValid), .dx(dx), .dy(dy), .btn(btn), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Monitor: capture pulses and check pulse width and packet latency.
  always @(negedge clk) begin
    if (rst) begin
      prevRx = 1'b0; prevErr = 1'b0; prevPkt = 1'b0;
    end else begin
      if (rxByteValid) begin
        gotBytes.push_back(rxByte);
        assertCount++;
        if (prevRx) begin failCount++; $display("[TB] FAIL rx_valid_width: got 2 consecutive cycles, expected 1"); end
      end
      if (frameErr) begin
        gotErr++;
        assertCount++;
        if (prevErr) begin failCount++; $display("[TB] FAIL frame_err_width: got 2 consecutive cycles, expected 1"); end
      end
      if (pktValid) begin
        gotPkts.push_back({dx, dy, btn, ovf});
        assertCount++;
        if (!prevRx) begin failCount++; $display("[TB] FAIL pkt_latency: prior rx_byte_valid %b, expected 1", prevRx); end
      end
      prevRx = rxByteValid; prevErr = frameErr; prevPkt = pktValid;
    end
  end

  // Reference model: what the receiver reports for one whole frame.
  function automatic void model_frame(input logic [7:0] b, input bit good);
    pkt_t p;
    if (!good) begin expErr++; mIdx = 0; return; end
    expBytes.push_back(b);
    lastGood = b;
    if (!pktEn) begin mIdx = 0; return; end
    if (mIdx == 0) begin
      if (b[3]) begin m0 = b; mIdx = 1; end
    end else if (mIdx == 1) begin
      m1 = b; mIdx = 2;
    end else begin
      p.dx = {m0[4], m1}; p.dy = {m0[5], b}; p.btn = m0[2:0]; p.ovf = m0[7:6];
      expPkts.push_back(p);
      mIdx = 0;
    end
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input int glitchBit);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2Data = bits[i];
      if (i == glitchBit) begin
        repeat (4) @(negedge clk);
        ps2Clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2Clk = 1'b1;
        repeat (HALF/2 - 6) @(negedge clk);
      end else begin
        repeat (HALF/2) @(negedge clk);
      end
      ps2Clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (HALF/2) @(negedge clk);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit badPar, input bit badStop, input int glitchBit);
    logic [10:0] f;
    f = {~badStop, (~^b) ^ badPar, b, 1'b0};
    send_bits(f, 11, glitchBit);
    repeat (GAP) @(negedge clk);
    model_frame(b, !badPar && !badStop);
  endtask

  task automatic start_test();
    repeat (TO + 50) @(negedge clk);
    gotBytes.delete(); gotPkts.delete(); gotErr = 0;
    expBytes.delete(); expPkts.delete(); expErr = 0; mIdx = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    assertCount++;
    if ({rxByte, rxByteValid, frameErr, pktValid, dx, dy, btn, ovf} !== '0) begin
      failCount++; $display("[TB] FAIL reset_outputs: got %h, expected 0", {rxByte, rxByteValid, frameErr, pktValid, dx, dy, btn, ovf});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    assertCount++;
    if ({rxByteValid, frameErr, pktValid} !== 3'b000) begin
      failCount++; $display("[TB] FAIL reset_idle_pulses: got %b, expected 000", {rxByteValid, frameErr, pktValid});
    end
  endtask

  task automatic test_ack();
    start_test(); pktEn = 1'b0;
    xfer(8'hFA, 0, 0, -1);
    assertCount++;
    if (gotBytes.size() != 1) begin failCount++; $display("[TB] FAIL ack_count: got %0d, expected 1", gotBytes.size()); end
    else begin
      assertCount++;
      if (gotBytes[0] !== 8'hFA) begin failCount++; $display("[TB] FAIL ack_byte: got %h, expected fa", gotBytes[0]); end
    end
    assertCount++;
    if (gotErr != 0 || gotPkts.size() != 0) begin failCount++; $display("[TB] FAIL ack_side: got err %0d pkts %0d, expected 0 0", gotErr, gotPkts.size()); end
  endtask

  task automatic test_movement();
    logic [7:0] seq [3] = '{8'h29, 8'h05, 8'hFB};
    start_test(); pktEn = 1'b1;
    for (int i = 0; i < 3; i++) xfer(seq[i], 0, 0, -1);
    assertCount++;
    if (gotBytes.size() != 3) begin failCount++; $display("[TB] FAIL move_bytes: got %0d, expected 3", gotBytes.size()); end
    else for (int i = 0; i < 3; i++) begin
      assertCount++;
      if (gotBytes[i] !== seq[i]) begin failCount++; $display("[TB] FAIL move_byte%0d: got %h, expected %h", i, gotBytes[i], seq[i]); end
    end
    assertCount++;
    if (gotPkts.size() != 1) begin failCount++; $display("[TB] FAIL move_pkts: got %0d, expected 1", gotPkts.size()); end
    else begin
      assertCount++;
      if (gotPkts[0] !== {9'h005, 9'h1FB, 3'b001, 2'b00}) begin
        failCount++; $display("[TB] FAIL move_pkt: got %h, expected %h", gotPkts[0], {9'h005, 9'h1FB, 3'b001, 2'b00});
      end
    end
  endtask

  task automatic test_errors();
    start_test(); pktEn = 1'b0;
    xfer(8'hFA, 1, 0, -1);
    assertCount++;
    if (gotErr != 1 || gotBytes.size() != 0) begin failCount++; $display("[TB] FAIL parity_err: got err %0d bytes %0d, expected 1 0", gotErr, gotBytes.size()); end
    assertCount++;
    if (rxByte !== lastGood) begin failCount++; $display("[TB] FAIL parity_hold: got %h, expected %h", rxByte, lastGood); end
    xfer(8'hFA, 0, 1, -1);
    assertCount++;
    if (gotErr != 2 || gotBytes.size() != 0) begin failCount++; $display("[TB] FAIL stop_err: got err %0d bytes %0d, expected 2 0", gotErr, gotBytes.size()); end
    assertCount++;
    if (rxByte !== lastGood) begin failCount++; $display("[TB] FAIL stop_hold: got %h, expected %h", rxByte, lastGood); end
  endtask

  task automatic test_resync();
    start_test(); pktEn = 1'b1;
    xfer(8'h05, 0, 0, -1); xfer(8'h08, 0, 0, -1); xfer(8'h10, 0, 0, -1); xfer(8'h20, 0, 0, -1);
    assertCount++;
    if (gotBytes.size() != 4) begin failCount++; $display("[TB] FAIL resync_bytes: got %0d, expected 4", gotBytes.size()); end
    assertCount++;
    if (gotPkts.size() != 1) begin failCount++; $display("[TB] FAIL resync_pkts: got %0d, expected 1", gotPkts.size()); end
    else begin
      assertCount++;
      if (gotPkts[0] !== {9'h010, 9'h020, 3'b000, 2'b00}) begin
        failCount++; $display("[TB] FAIL resync_pkt: got %h, expected %h", gotPkts[0], {9'h010, 9'h020, 3'b000, 2'b00});
      end
    end
  endtask

  task automatic test_timeout();
    logic [10:0] f;
    start_test(); pktEn = 1'b0;
    f = {1'b1, 1'b1, 8'hFA, 1'b0};
    send_bits(f, 5, -1);
    repeat (TO + 10) @(negedge clk);
    assertCount++;
    if (gotErr != 1 || gotBytes.size() != 0) begin failCount++; $display("[TB] FAIL timeout_err: got err %0d bytes %0d, expected 1 0", gotErr, gotBytes.size()); end
    xfer(8'hFA, 0, 0, -1);
    assertCount++;
    if (gotBytes.size() != 1 || gotErr != 1) begin failCount++; $display("[TB] FAIL timeout_recover: got bytes %0d err %0d, expected 1 1", gotBytes.size(), gotErr); end
    else begin
      assertCount++;
      if (gotBytes[0] !== 8'hFA) begin failCount++; $display("[TB] FAIL timeout_byte: got %h, expected fa", gotBytes[0]); end
    end
  endtask

  task automatic test_glitch();
    start_test(); pktEn = 1'b0;
    xfer(8'hA5, 0, 0, 4);
    assertCount++;
    if (gotBytes.size() != 1 || gotErr != 0) begin failCount++; $display("[TB] FAIL glitch_count: got bytes %0d err %0d, expected 1 0", gotBytes.size(), gotErr); end
    else begin
      assertCount++;
      if (gotBytes[0] !== 8'hA5) begin failCount++; $display("[TB] FAIL glitch_byte: got %h, expected a5", gotBytes[0]); end
    end
  endtask

  task automatic test_pkt_en_drop();
    start_test(); pktEn = 1'b1;
    xfer(8'h08, 0, 0, -1); xfer(8'h01, 0, 0, -1);
    pktEn = 1'b0; mIdx = 0;
    repeat (5) @(negedge clk);
    pktEn = 1'b1;
    xfer(8'h02, 0, 0, -1);
    xfer(8'h09, 0, 0, -1); xfer(8'h03, 0, 0, -1); xfer(8'h04, 0, 0, -1);
    assertCount++;
    if (gotPkts.size() != 1) begin failCount++; $display("[TB] FAIL en_drop_pkts: got %0d, expected 1", gotPkts.size()); end
    else begin
      assertCount++;
      if (gotPkts[0] !== {9'h003, 9'h004, 3'b001, 2'b00}) begin
        failCount++; $display("[TB] FAIL en_drop_pkt: got %h, expected %h", gotPkts[0], {9'h003, 9'h004, 3'b001, 2'b00});
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    start_test(); pktEn = 1'b1;
    xfer(8'h08, 0, 0, -1); xfer(8'h01, 0, 0, -1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    assertCount++;
    if ({rxByte, rxByteValid, frameErr, pktValid, dx, dy, btn, ovf} !== '0) begin
      failCount++; $display("[TB] FAIL midreset_outputs: got %h, expected 0", {rxByte, rxByteValid, frameErr, pktValid, dx, dy, btn, ovf});
    end
    rst = 1'b0;
    lastGood = 8'h00;
    gotBytes.delete(); gotPkts.delete(); gotErr = 0;
    expBytes.delete(); expPkts.delete(); expErr = 0; mIdx = 0;
    xfer(8'h08, 0, 0, -1); xfer(8'h01, 0, 0, -1); xfer(8'h02, 0, 0, -1);
    assertCount++;
    if (gotPkts.size() != 1 || gotErr != 0) begin failCount++; $display("[TB] FAIL midreset_pkts: got pkts %0d err %0d, expected 1 0", gotPkts.size(), gotErr); end
    else begin
      assertCount++;
      if (gotPkts[0] !== {9'h001, 9'h002, 3'b000, 2'b00}) begin
        failCount++; $display("[TB] FAIL midreset_pkt: got %h, expected %h", gotPkts[0], {9'h001, 9'h002, 3'b000, 2'b00});
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int kind;
    for (int round = 0; round < 2; round++) begin
      start_test();
      pktEn = (round == 0);
      for (int n = 0; n < 12; n++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 2) == 0) b[3] = 1'b1;
        kind = $urandom_range(0, 7);
        xfer(b, kind == 0, kind == 1, -1);
      end
      assertCount++;
      if (gotBytes.size() != expBytes.size()) begin
        failCount++; $display("[TB] FAIL rand%0d_bytes: got %0d, expected %0d", round, gotBytes.size(), expBytes.size());
      end else foreach (expBytes[i]) begin
        assertCount++;
        if (gotBytes[i] !== expBytes[i]) begin failCount++; $display("[TB] FAIL rand%0d_byte%0d: got %h, expected %h", round, i, gotBytes[i], expBytes[i]); end
      end
      assertCount++;
      if (gotPkts.size() != expPkts.size()) begin
        failCount++; $display("[TB] FAIL rand%0d_pkts: got %0d, expected %0d", round, gotPkts.size(), expPkts.size());
      end else foreach (expPkts[i]) begin
        assertCount++;
        if (gotPkts[i] !== expPkts[i]) begin failCount++; $display("[TB] FAIL rand%0d_pkt%0d: got %h, expected %h", round, i, gotPkts[i], expPkts[i]); end
      end
      assertCount++;
      if (gotErr != expErr) begin failCount++; $display("[TB] FAIL rand%0d_err: got %0d, expected %0d", round, gotErr, expErr); end
      assertCount++;
      if (rxByte !== lastGood) begin failCount++; $display("[TB] FAIL rand%0d_last: got %h, expected %h", round, rxByte, lastGood); end
    end
  endtask

  initial begin
    rst = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1; pktEn = 1'b0;
    lastGood = 8'h00; gotErr = 0; expErr = 0; mIdx = 0;
    prevRx = 1'b0; prevErr = 1'b0; prevPkt = 1'b0;
    test_reset();
    test_ack();
    test_movement();
    test_errors();
    test_resync();
    test_timeout();
    test_glitch();
    test_pkt_en_drop();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
